// File: rtl/div_sweep_ctrl.sv
// rtl/div_sweep_ctrl.sv - sweeps four operand pairs through a divider stage and streams the quotients out
// Each pair is held on sel for SETTLE cycles, captured, then all four results are presented with valid/ready.
module div_sweep_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] div_out,
  input  logic             div_err,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic [1:0]       res_idx,
  output logic [2:0]       err_count,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, OUT} state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

  state_t                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [1:0]              rd_idx_q, rd_idx_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              err_cnt_q, err_cnt_d;
  logic [3:0][WIDTH-1:0]   q_buf_q, q_buf_d;
  logic [3:0]              e_buf_q, e_buf_d;
  logic                    done_q, done_d;
  logic                    in_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rd_idx_q  <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      q_buf_q   <= '0;
      e_buf_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rd_idx_q  <= rd_idx_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      q_buf_q   <= q_buf_d;
      e_buf_q   <= e_buf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rd_idx_d  = rd_idx_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    q_buf_d   = q_buf_q;
    e_buf_d   = e_buf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d     = '0;
          cnt_d     = '0;
          err_cnt_d = '0;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      CAPTURE: begin
        q_buf_d[sel_q] = div_out;
        e_buf_d[sel_q] = div_err;
        err_cnt_d      = err_cnt_q + {2'b00, div_err};
        if (sel_q == 2'd3) begin
          rd_idx_d = '0;
          state_d  = OUT;
        end else begin
          sel_d   = sel_q + 2'd1;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      OUT: begin
        if (res_ready) begin
          if (rd_idx_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst_n so an asserted reset silences them before the edge lands.
  always_comb begin
    in_out    = rst_n && (state_q == OUT);
    busy      = rst_n && (state_q != IDLE);
    res_valid = in_out;
    res_idx   = rd_idx_q;
    res_err   = in_out && e_buf_q[rd_idx_q];
    res_data  = '0;
    if (in_out) begin
      res_data = e_buf_q[rd_idx_q] ? '1 : q_buf_q[rd_idx_q];
    end
    done      = rst_n && done_q;
    sel       = sel_q;
    err_count = err_cnt_q;
  end

endmodule
